// File: rtl/s1423_n100_capture_pkg.sv
// s1423_n100_capture shared definitions: FSM state codes, fault-mode
// encodings and default MISR constants.
package s1423_cap_pkg;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_PAT = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_CAPTURE  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  typedef enum logic [1:0] {
    FI_PASS   = 2'd0,
    FI_INVERT = 2'd1,
    FI_STUCK0 = 2'd2,
    FI_STUCK1 = 2'd3
  } fi_mode_t;

  // Bit actually compacted when a fault is injected on a pattern.
  function automatic logic fi_apply(input logic b, input logic [1:0] mode);
    logic r;
    r = b;
    case (mode)
      FI_INVERT: r = ~b;
      FI_STUCK0: r = 1'b0;
      FI_STUCK1: r = 1'b1;
      default:   r = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/s1423_n100_capture_if.sv
// Pattern handshake and capture strobe between the stimulus source (master)
// and the capture stage (slave).
interface s1423_n100_capture_if;
  logic pat_valid;
  logic pat_ready;
  logic n100;
  logic cap_valid;
  logic cap_bit;

  modport master (
    output pat_valid,
    output n100,
    input  pat_ready,
    input  cap_valid,
    input  cap_bit
  );

  modport slave (
    input  pat_valid,
    input  n100,
    output pat_ready,
    output cap_valid,
    output cap_bit
  );
endinterface

// File: rtl/s1423_n100_capture_misr.sv
// Serial-input MISR used to compact captured n100 bits into a signature.
module s1423_misr
  import s1423_cap_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  // Seed on reset/load, otherwise shift left with feedback when MSB is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (shift) begin
      sig <= {sig[SIG_W-2:0], 1'b0}
           ^ (sig[SIG_W-1] ? POLY : '0)
           ^ {{(SIG_W-1){1'b0}}, din};
    end
  end

endmodule

// File: rtl/s1423_n100_capture.sv
// Capture stage for the s1423 n100 cone: pattern handshake, programmable
// settle delay, n100 sampling, MISR compaction and pattern counting.
// Optional fault injection on the compacted bit: S1423_N100_FAULT_INJ_EN.
module s1423_n100_capture
  import s1423_cap_pkg::*;
#(
  parameter int               SIG_W        = 16,
  parameter logic [SIG_W-1:0] POLY         = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED         = SIG_W'(DEF_SEED),
  parameter int               CNT_W        = 16,
  parameter int               NUM_PATTERNS = 256,
  parameter int               SETTLE_CYC   = 2
) (
  input  logic                 CK,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic                 abort,
  s1423_n100_capture_if.slave  pat,
`ifdef S1423_N100_FAULT_INJ_EN
  input  logic                 fi_en,
  input  logic [CNT_W-1:0]     fi_pattern,
  input  logic [1:0]           fi_mode,
`endif
  output logic [SIG_W-1:0]     signature,
  output logic [CNT_W-1:0]     pat_count,
  output logic                 busy,
  output logic                 done
);

  localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(NUM_PATTERNS);

  logic [2:0]       state;
  logic [7:0]       settle_cnt;
  logic             cap_valid_q;
  logic             cap_bit_q;
  logic             comp_bit;
  logic             misr_load;
  logic             misr_shift;
  logic [CNT_W-1:0] count_nxt;

  assign count_nxt = pat_count + CNT_W'(1);

  // Bit fed to the MISR and reported on cap_bit.
  always_comb begin
`ifdef S1423_N100_FAULT_INJ_EN
    comp_bit = (fi_en && (pat_count == fi_pattern)) ? fi_apply(pat.n100, fi_mode)
                                                      : pat.n100;
`else
    comp_bit = pat.n100;
`endif
  end

  // abort outranks both the reload on start and the capture shift.
  assign misr_load  = !abort && start && ((state == ST_IDLE) || (state == ST_DONE));
  assign misr_shift = !abort && (state == ST_CAPTURE);

  s1423_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (CK),
    .rst_n (RESET_N),
    .load  (misr_load),
    .shift (misr_shift),
    .din   (comp_bit),
    .sig   (signature)
  );

  // FSM, settle counter, pattern counter and registered capture strobe.
  always_ff @(posedge CK) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      pat_count   <= '0;
      cap_valid_q <= 1'b0;
      cap_bit_q   <= 1'b0;
    end else begin
      cap_valid_q <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              pat_count <= '0;
              state     <= ST_WAIT_PAT;
            end
          end
          ST_WAIT_PAT: begin
            if (pat.pat_valid) begin
              settle_cnt <= SETTLE_INIT;
              state      <= (SETTLE_INIT != 8'd0) ? ST_SETTLE : ST_CAPTURE;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt != 8'd0) settle_cnt <= settle_cnt - 8'd1;
            if (settle_cnt <= 8'd1) state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            cap_valid_q <= 1'b1;
            cap_bit_q   <= comp_bit;
            pat_count   <= count_nxt;
            state       <= (count_nxt == LAST_COUNT) ? ST_DONE : ST_WAIT_PAT;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Status decoded from state only.
  always_comb begin
    pat.pat_ready = (state == ST_WAIT_PAT);
    busy          = (state == ST_WAIT_PAT) || (state == ST_SETTLE) || (state == ST_CAPTURE);
    done          = (state == ST_DONE);
    pat.cap_valid = cap_valid_q;
    pat.cap_bit   = cap_bit_q;
  end

endmodule

// File: tb/tb_s1423_n100_capture.sv
// Randomized self-checking bench for s1423_n100_capture with a behavioural
// signature/count model. Build with S1423_N100_FAULT_INJ_EN to cover the
// fault-injection ports.
module tb_s1423_n100_capture;

  localparam int NP = 4;
  localparam int ST = 2;
`ifdef S1423_N100_FAULT_INJ_EN
  localparam bit FI_BUILD = 1'b1;
`else
  localparam bit FI_BUILD = 1'b0;
`endif

  logic        CK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] signature;
  logic [15:0] pat_count;
  logic        busy;
  logic        done;
`ifdef S1423_N100_FAULT_INJ_EN
  logic        fi_en = 1'b0;
  logic [15:0] fi_pattern = '0;
  logic [1:0]  fi_mode = '0;
`endif

  s1423_n100_capture_if pif ();

  s1423_n100_capture #(
    .SIG_W        (16),
    .POLY         (16'h1021),
    .SEED         (16'hFFFF),
    .CNT_W        (16),
    .NUM_PATTERNS (NP),
    .SETTLE_CYC   (ST)
  ) dut (
    .CK         (CK),
    .RESET_N    (RESET_N),
    .start      (start),
    .abort      (abort),
    .pat        (pif),
`ifdef S1423_N100_FAULT_INJ_EN
    .fi_en      (fi_en),
    .fi_pattern (fi_pattern),
    .fi_mode    (fi_mode),
`endif
    .signature  (signature),
    .pat_count  (pat_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 CK = ~CK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned sig_m;
  int unsigned cnt_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signature as a polynomial over GF(2): multiply by x, add the new bit,
  // reduce by x^16 + 0x1021.
  function automatic int unsigned misr_ref(input int unsigned s, input logic b);
    int unsigned v;
    v = s * 2 + 32'(b);
    if (v >= 32'h10000) v = (v - 32'h10000) ^ 32'h1021;
    return v;
  endfunction

  function automatic logic fault_ref(input logic b, input logic [1:0] m);
    if (m == 2'd0) return b;
    if (m == 2'd1) return !b;
    if (m == 2'd2) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    sig_m = 32'hFFFF;
    cnt_m = 0;
    check("start_ready", 32'(pif.pat_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_sig", 32'(signature), sig_m);
    check("start_cnt", 32'(pat_count), cnt_m);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sig", 32'(signature), sig_m);
    check("abort_cnt", 32'(pat_count), cnt_m);
  endtask

  // One pattern: accept, SETTLE noise, exact capture edge, model update.
  task automatic send_pattern(input logic b, input bit hold, input bit noise,
                              input logic fe, input logic [1:0] fm, input logic [15:0] fp);
    logic eff;
`ifdef S1423_N100_FAULT_INJ_EN
    fi_en = fe; fi_mode = fm; fi_pattern = fp;
`endif
    check("ready", 32'(pif.pat_ready), 32'd1);
    pif.pat_valid = 1'b1;
    pif.n100 = 1'($urandom);
    tick();
    check("cap_pulse_low", 32'(pif.cap_valid), 32'd0);
    check("settle_ready", 32'(pif.pat_ready), 32'd0);
    for (int e = 1; e <= ST + 1; e++) begin
      pif.pat_valid = hold ? 1'b1 : (noise ? 1'($urandom) : 1'b0);
      pif.n100 = (e == ST + 1) ? b : 1'($urandom);
      start = noise ? 1'($urandom) : 1'b0;
      tick();
      if (e <= ST) check("no_early_cap", 32'(pif.cap_valid), 32'd0);
    end
    start = 1'b0;
    pif.pat_valid = hold;
    eff = (FI_BUILD && fe && (cnt_m == 32'(fp))) ? fault_ref(b, fm) : b;
    sig_m = misr_ref(sig_m, eff);
    cnt_m++;
    check("cap_valid", 32'(pif.cap_valid), 32'd1);
    check("cap_bit", 32'(pif.cap_bit), 32'(eff));
    check("signature", 32'(signature), sig_m);
    check("pat_count", 32'(pat_count), cnt_m);
    check("done", 32'(done), (cnt_m == NP) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.pat_valid = 1'b0;
    pif.n100 = 1'b0;
    sig_m = 32'hFFFF;
    cnt_m = 0;

    // reset state
    tick(); tick();
    check("rst_sig", 32'(signature), 32'hFFFF);
    check("rst_cnt", 32'(pat_count), 32'd0);
    check("rst_cap_valid", 32'(pif.cap_valid), 32'd0);
    check("rst_cap_bit", 32'(pif.cap_bit), 32'd0);
    check("rst_ready", 32'(pif.pat_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    RESET_N = 1'b1;
    tick();

    // single pattern, n100=0 then n100=1
    start_run();
    send_pattern(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    check("sig_n0", 32'(signature), 32'hEFDF);
    tick();
    check("pulse_one_cycle", 32'(pif.cap_valid), 32'd0);
    do_abort();
    start_run();
    send_pattern(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    check("sig_n1", 32'(signature), 32'hEFDE);
    do_abort();

    // full run with pat_valid held high, then DONE ignores patterns
    start_run();
    for (int p = 0; p < NP; p++) send_pattern(1'($urandom), 1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("done_hold", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_ready", 32'(pif.pat_ready), 32'd0);
      check("done_no_cap", 32'(pif.cap_valid), 32'd0);
      check("done_cnt", 32'(pat_count), 32'(NP));
      check("done_sig", 32'(signature), sig_m);
    end
    pif.pat_valid = 1'b0;

    // randomized runs restarted from DONE, with noise and fault injection
    for (int r = 0; r < 6; r++) begin
      start_run();
      for (int p = 0; p < NP; p++)
        send_pattern(1'($urandom), 1'($urandom), 1'b1, 1'($urandom),
                     2'($urandom), 16'($urandom_range(0, NP - 1)));
    end

    // abort + start in SETTLE of the second pattern
    start_run();
    send_pattern(1'($urandom), 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    pif.pat_valid = 1'b1;
    tick();
    pif.pat_valid = 1'b0;
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_cnt", 32'(pat_count), 32'd1);
    check("ab_sig", 32'(signature), sig_m);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ab_no_cap", 32'(pif.cap_valid), 32'd0);
      check("ab_idle", 32'(busy), 32'd0);
    end
    start_run();

    // reset mid-SETTLE
    send_pattern(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    pif.pat_valid = 1'b1;
    tick();
    pif.pat_valid = 1'b0;
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    sig_m = 32'hFFFF;
    cnt_m = 0;
    check("mr_sig", 32'(signature), 32'hFFFF);
    check("mr_cnt", 32'(pat_count), 32'd0);
    check("mr_cap_valid", 32'(pif.cap_valid), 32'd0);
    check("mr_cap_bit", 32'(pif.cap_bit), 32'd0);
    check("mr_ready", 32'(pif.pat_ready), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mr_no_cap", 32'(pif.cap_valid), 32'd0);
      check("mr_sig_hold", 32'(signature), 32'hFFFF);
    end

`ifdef S1423_N100_FAULT_INJ_EN
    // directed fault injection: invert on pattern 0, then disabled
    start_run();
    send_pattern(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'd0);
    check("fi_cap_bit", 32'(pif.cap_bit), 32'd1);
    check("fi_sig", 32'(signature), 32'hEFDE);
    do_abort();
    start_run();
    send_pattern(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'd0);
    check("fi_off_sig", 32'(signature), 32'hEFDF);
    do_abort();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
